// File: rtl/frankie_io_ctrl_pkg.sv
// Shared definitions for the Frankie multi-channel I/O controller.
// Register offsets are functions of the channel count.
package frankie_io_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int IN_BASE   = 0;

    function automatic int in_addr(int k);
        return IN_BASE + k;
    endfunction

    function automatic int out_addr(int ch, int k);
        return ch + k;
    endfunction

    function automatic int status_addr(int ch);
        return 2 * ch;
    endfunction

    function automatic int mask_addr(int ch);
        return 2 * ch + 1;
    endfunction

endpackage

// File: rtl/frankie_io_ctrl_if.sv
// Register-mapped access port between the core and the I/O controller.
// The core drives the master side; the controller is the slave.
interface frankie_io_if #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 16
);
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic              rd_en;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;

    modport master (
        output addr, wr_en, rd_en, wdata,
        input  rdata
    );

    modport slave (
        input  addr, wr_en, rd_en, wdata,
        output rdata
    );
endinterface

// File: rtl/frankie_io_ctrl_chan.sv
// One I/O channel: input synchroniser, change flag, output register.
// rx_flag set takes priority over a same-edge clearing read.
import frankie_io_pkg::*;

module frankie_io_chan #(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_in,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_clr,
    output logic [WIDTH-1:0] in_reg,
    output logic [WIDTH-1:0] pin_out,
    output logic             out_stb,
    output logic             rx_flag
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic             changed;

    assign changed = (sync_q[SYNC_STAGES-1] != in_reg);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            in_reg  <= '0;
            rx_flag <= 1'b0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            in_reg <= sync_q[SYNC_STAGES-1];
            if (changed)
                rx_flag <= 1'b1;
            else if (rd_clr)
                rx_flag <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pin_out <= '0;
            out_stb <= 1'b0;
        end else begin
            if (wr)
                pin_out <= wdata;
            out_stb <= wr;
        end
    end

endmodule

// File: rtl/frankie_io_ctrl.sv
// Frankie I/O controller top: address decode, read mux, MASK and irq.
// Channels are instantiated per slot; io_in/io_out pack channel k at [k*WIDTH +: WIDTH].
import frankie_io_pkg::*;

module frankie_io_ctrl #(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    frankie_io_if.slave               bus,
    input  logic [CHANNELS*WIDTH-1:0] io_in,
    output logic [CHANNELS*WIDTH-1:0] io_out,
    output logic [CHANNELS-1:0]       out_stb,
    output logic                      irq
);

    localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(status_addr(CHANNELS));
    localparam logic [ADDR_W-1:0] MASK_A   = ADDR_W'(mask_addr(CHANNELS));

    logic [WIDTH-1:0]    in_val [CHANNELS];
    logic [CHANNELS-1:0] rx_flag;
    logic [CHANNELS-1:0] rd_clr;
    logic [CHANNELS-1:0] wr_sel;
    logic [CHANNELS-1:0] mask;
    logic                mask_wr;
    logic [WIDTH-1:0]    rd_mux;

    always_comb begin
        rd_clr = '0;
        wr_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            rd_clr[k] = bus.rd_en && (bus.addr == ADDR_W'(in_addr(k)));
            wr_sel[k] = bus.wr_en &&
                        (bus.addr == ADDR_W'(out_addr(CHANNELS, k)));
        end
    end

    assign mask_wr = bus.wr_en && (bus.addr == MASK_A);

    // Unmapped offsets fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.addr == ADDR_W'(in_addr(k)))
                rd_mux = in_val[k];
            if (bus.addr == ADDR_W'(out_addr(CHANNELS, k)))
                rd_mux = io_out[k*WIDTH +: WIDTH];
        end
        if (bus.addr == STATUS_A)
            rd_mux = WIDTH'(rx_flag);
        if (bus.addr == MASK_A)
            rd_mux = WIDTH'(mask);
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        frankie_io_chan #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .pin_in  (io_in[k*WIDTH +: WIDTH]),
            .wr      (wr_sel[k]),
            .wdata   (bus.wdata),
            .rd_clr  (rd_clr[k]),
            .in_reg  (in_val[k]),
            .pin_out (io_out[k*WIDTH +: WIDTH]),
            .out_stb (out_stb[k]),
            .rx_flag (rx_flag[k])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mask      <= '0;
            bus.rdata <= '0;
        end else begin
            if (mask_wr)
                mask <= bus.wdata[CHANNELS-1:0];
            if (bus.rd_en)
                bus.rdata <= rd_mux;
        end
    end

    assign irq = |(rx_flag & mask);

endmodule

// File: tb/tb_frankie_io_ctrl.sv
// Directed bench for frankie_io_ctrl (4 channels x 16 bits).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_frankie_io_ctrl;

    logic        clock;
    logic        reset;
    logic [63:0] io_in;
    logic [63:0] io_out;
    logic [3:0]  out_stb;
    logic        irq;

    int n_vec;
    int n_err;

    frankie_io_if #(.ADDR_W(4), .WIDTH(16)) bus ();

    frankie_io_ctrl #(
        .WIDTH       (16),
        .CHANNELS    (4),
        .SYNC_STAGES (2),
        .ADDR_W      (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .io_in   (io_in),
        .io_out  (io_out),
        .out_stb (out_stb),
        .irq     (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic rd(logic [3:0] a);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        bus.addr  = a;
    endtask

    task automatic wr(logic [3:0] a, logic [15:0] d);
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b0;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    task automatic pin(int k, logic [15:0] v);
        io_in[k*16 +: 16] = v;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        io_in = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        idle();

        // 1: reset hold with activity, then flag after 3 clocks
        pin(0, 16'd5040);
        for (int i = 0; i < 4; i++) begin
            bus.addr  = 4'($urandom);
            bus.wdata = 16'($urandom);
            bus.wr_en = 1'($urandom);
            bus.rd_en = 1'($urandom);
            tick();
            check("rst_rdata", 64'(bus.rdata), 64'h0);
            check("rst_io_out", io_out, 64'h0);
            check("rst_stb", 64'(out_stb), 64'h0);
            check("rst_irq", 64'(irq), 64'h0);
        end
        idle();
        reset = 1'b1;
        wr(4'd9, 16'h000F);
        tick();
        check("post_rst_e1_irq", 64'(irq), 64'h0);
        rd(4'd8);
        tick();
        check("post_rst_e2_irq", 64'(irq), 64'h0);
        check("post_rst_e2_stat", 64'(bus.rdata), 64'h0);
        tick();
        check("post_rst_e3_irq", 64'(irq), 64'h1);
        check("post_rst_e3_stat", 64'(bus.rdata), 64'h0);
        tick();
        check("post_rst_e4_stat", 64'(bus.rdata), 64'h1);
        rd(4'd0);
        tick();
        check("in0_rdata", 64'(bus.rdata), 64'd5040);
        check("in0_clr_irq", 64'(irq), 64'h0);

        // 2: ch1 input and clearing read
        idle();
        pin(1, 16'h00FF);
        tick();
        tick();
        check("ch1_e2_irq", 64'(irq), 64'h0);
        tick();
        check("ch1_e3_irq", 64'(irq), 64'h1);
        rd(4'd1);
        tick();
        check("in1_rdata", 64'(bus.rdata), 64'h00FF);
        check("in1_clr_irq", 64'(irq), 64'h0);
        rd(4'd8);
        tick();
        check("stat_after_in1", 64'(bus.rdata), 64'h0);

        // 3: set beats clear on ch2
        idle();
        pin(2, 16'h0001);
        tick();
        tick();
        tick();
        check("ch2_set_irq", 64'(irq), 64'h1);
        rd(4'd2);
        tick();
        check("in2_first", 64'(bus.rdata), 64'h0001);
        check("in2_first_irq", 64'(irq), 64'h0);
        idle();
        pin(2, 16'h0002);
        tick();
        tick();
        rd(4'd2);
        tick();
        check("sbc_rdata", 64'(bus.rdata), 64'h0001);
        check("sbc_irq", 64'(irq), 64'h1);
        rd(4'd8);
        tick();
        check("sbc_stat", 64'(bus.rdata), 64'h4);
        rd(4'd2);
        tick();
        check("sbc_second", 64'(bus.rdata), 64'h0002);
        check("sbc_second_irq", 64'(irq), 64'h0);
        rd(4'd8);
        tick();
        check("sbc_stat_clr", 64'(bus.rdata), 64'h0);

        // 4: output writes, strobes, readback, rd+wr same cycle
        wr(4'd7, 16'h1234);
        tick();
        check("out3_val", 64'(io_out[48 +: 16]), 64'h1234);
        check("out3_stb1", 64'(out_stb), 64'h8);
        tick();
        check("out3_stb2", 64'(out_stb), 64'h8);
        idle();
        tick();
        check("out3_stb_off", 64'(out_stb), 64'h0);
        check("out3_hold", io_out, 64'h1234_0000_0000_0000);
        rd(4'd7);
        tick();
        check("out3_read", 64'(bus.rdata), 64'h1234);
        idle();
        tick();
        check("rdata_hold", 64'(bus.rdata), 64'h1234);
        bus.rd_en = 1'b1;
        bus.wr_en = 1'b1;
        bus.addr  = 4'd7;
        bus.wdata = 16'hBEEF;
        tick();
        check("rw_pre_val", 64'(bus.rdata), 64'h1234);
        check("rw_new_out", 64'(io_out[48 +: 16]), 64'hBEEF);
        check("rw_stb", 64'(out_stb), 64'h8);

        // 5: irq masking
        wr(4'd9, 16'h0005);
        tick();
        idle();
        pin(1, 16'h00FE);
        tick();
        tick();
        tick();
        check("mask_ch1_irq", 64'(irq), 64'h0);
        rd(4'd8);
        tick();
        check("mask_ch1_stat", 64'(bus.rdata), 64'h2);
        idle();
        pin(2, 16'h0003);
        tick();
        tick();
        tick();
        check("mask_ch2_irq", 64'(irq), 64'h1);
        wr(4'd9, 16'h0000);
        tick();
        check("mask0_irq", 64'(irq), 64'h0);
        rd(4'd8);
        tick();
        check("mask0_stat", 64'(bus.rdata), 64'h6);
        rd(4'd9);
        tick();
        check("mask0_read", 64'(bus.rdata), 64'h0);
        wr(4'd9, 16'hFFF5);
        tick();
        check("mask5_irq", 64'(irq), 64'h1);
        rd(4'd9);
        tick();
        check("mask_trunc", 64'(bus.rdata), 64'h5);

        // 6: async reset during a write, then unmapped address
        wr(4'd4, 16'hA5A5);
        tick();
        check("out0_val", 64'(io_out[15:0]), 64'hA5A5);
        check("out0_stb", 64'(out_stb), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_io_out", io_out, 64'h0);
        check("arst_stb", 64'(out_stb), 64'h0);
        check("arst_irq", 64'(irq), 64'h0);
        check("arst_rdata", 64'(bus.rdata), 64'h0);
        tick();
        idle();
        reset = 1'b1;
        wr(4'd15, 16'hFFFF);
        tick();
        check("unmap_wr_out", io_out, 64'h0);
        check("unmap_wr_stb", 64'(out_stb), 64'h0);
        rd(4'd15);
        tick();
        check("unmap_rd", 64'(bus.rdata), 64'h0);
        rd(4'd9);
        tick();
        check("unmap_mask", 64'(bus.rdata), 64'h0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
